// File: rtl/countdown_timer_if.sv
// Handshake bundle for countdown_timer: control strobes in, count and status out.
interface countdown_timer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ena;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             abort;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             expired;

    modport master (
        output ena, load, load_value, abort,
        input  value, busy, expired
    );

    modport slave (
        input  ena, load, load_value, abort,
        output value, busy, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter with a one-cycle expiry strobe and optional auto-reload.
module countdown_timer #(
    parameter int unsigned UPPER    = 255,
    parameter int unsigned RELOAD   = 0,
    parameter int unsigned PRESCALE = 1
) (
    input logic               clk,
    input logic               rst,
    countdown_timer_if.slave  bus
);
    localparam int unsigned WIDTH = $clog2(UPPER + 1);
    localparam int unsigned PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] UpperW = WIDTH'(UPPER);
    localparam logic [PW-1:0]    PreMax = PW'(PRESCALE - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             expired_q, expired_d;
    logic [WIDTH-1:0] clamped;
    logic             tick;

    assign clamped = (bus.load_value > UpperW) ? UpperW : bus.load_value;
    assign tick    = (state_q == StRun) && bus.ena && (pre_q == PreMax);

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        reload_d  = reload_q;
        pre_d     = pre_q;
        expired_d = 1'b0;
        if (bus.load) begin
            reload_d = clamped;
            value_d  = clamped;
            pre_d    = '0;
            if (clamped != '0) begin
                state_d = StRun;
            end else begin
                // Zero load expires immediately and never re-arms.
                state_d   = StIdle;
                expired_d = 1'b1;
            end
        end else if (bus.abort) begin
            if (state_q == StRun) begin
                state_d = StIdle;
                value_d = '0;
                pre_d   = '0;
            end
        end else if ((state_q == StRun) && bus.ena) begin
            if (tick) begin
                pre_d = '0;
                if (value_q > WIDTH'(1)) begin
                    value_d = value_q - WIDTH'(1);
                end else begin
                    expired_d = 1'b1;
                    if (RELOAD != 0) begin
                        value_d = reload_q;
                    end else begin
                        value_d = '0;
                        state_d = StIdle;
                    end
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            value_q   <= '0;
            reload_q  <= '0;
            pre_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            reload_q  <= reload_d;
            pre_q     <= pre_d;
            expired_q <= expired_d;
        end
    end

    assign bus.value   = value_q;
    assign bus.busy    = (state_q == StRun);
    assign bus.expired = expired_q;
endmodule
